// File: rtl/axi_slv_wr_responder.sv
// AXI3 write-path slave responder: queues AW requests, retires W beats against
// the head request into a memory port, and returns one B response per burst.
module axi_slv_wr_responder #(
  parameter int AXI_ADDR_W      = 32,
  parameter int AXI_ID_W        = 4,
  parameter int AXI_DATA_W      = 32,
  parameter int SLV_OSTDREQ_NUM = 4,
  parameter int SLV_BQ_NUM      = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // AW channel
  input  logic                  in_awvalid,
  output logic                  out_awready,
  input  logic [AXI_ADDR_W-1:0] in_awaddr,
  input  logic [3:0]            in_awlen,
  input  logic [AXI_ID_W-1:0]   in_awid,
  // W channel
  input  logic                  in_wvalid,
  output logic                  out_wready,
  input  logic                  in_wlast,
  input  logic [AXI_ID_W-1:0]   in_wid,
  input  logic [AXI_DATA_W-1:0] in_wdata,
  input  logic [3:0]            in_wstrb,
  // B channel
  output logic                  out_bvalid,
  input  logic                  in_bready,
  output logic [AXI_ID_W-1:0]   out_bid,
  output logic [1:0]            out_bresp,
  // memory model port
  output logic                  mem_we,
  output logic [AXI_ADDR_W-1:0] mem_addr,
  output logic [AXI_DATA_W-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  output logic [7:0]            err_cnt
);

  // Every channel follows strict valid/ready: a transfer happens on the rising
  // edge where valid && ready; valid never depends on ready, and the B payload
  // is held stable while out_bvalid is high and in_bready is low.

  localparam int AQ_PW = $clog2(SLV_OSTDREQ_NUM);
  localparam int AQ_CW = AQ_PW + 1;
  localparam int BQ_PW = $clog2(SLV_BQ_NUM);
  localparam int BQ_CW = BQ_PW + 1;

  localparam logic [AQ_CW-1:0] AQ_FULL = AQ_CW'(SLV_OSTDREQ_NUM);
  localparam logic [BQ_CW-1:0] BQ_FULL = BQ_CW'(SLV_BQ_NUM);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // AW queue state
  logic [AXI_ADDR_W-1:0] aq_addr_q [SLV_OSTDREQ_NUM];
  logic [3:0]            aq_len_q  [SLV_OSTDREQ_NUM];
  logic [AXI_ID_W-1:0]   aq_id_q   [SLV_OSTDREQ_NUM];
  logic [AQ_PW-1:0]      aq_wr_ptr_q, aq_wr_ptr_d;
  logic [AQ_PW-1:0]      aq_rd_ptr_q, aq_rd_ptr_d;
  logic [AQ_CW-1:0]      aq_count_q,  aq_count_d;

  // B queue state
  logic [AXI_ID_W-1:0]   bq_id_q   [SLV_BQ_NUM];
  logic [1:0]            bq_resp_q [SLV_BQ_NUM];
  logic [BQ_PW-1:0]      bq_wr_ptr_q, bq_wr_ptr_d;
  logic [BQ_PW-1:0]      bq_rd_ptr_q, bq_rd_ptr_d;
  logic [BQ_CW-1:0]      bq_count_q,  bq_count_d;

  // burst tracking
  logic [3:0]            beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic [AXI_ADDR_W-1:0] head_addr;
  logic [3:0]            head_len;
  logic [AXI_ID_W-1:0]   head_id;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  b_fire;
  logic                  terminal;
  logic                  beat_err;
  logic                  burst_err;
  logic                  aq_pop;
  logic                  bq_push;
  logic [1:0]            push_resp;

  assign head_addr = aq_addr_q[aq_rd_ptr_q];
  assign head_len  = aq_len_q[aq_rd_ptr_q];
  assign head_id   = aq_id_q[aq_rd_ptr_q];

  // Readies come straight from registered counts, so an AW is never visible to
  // the W side before the cycle after its handshake and a full queue does not
  // reopen on a same-cycle pop.
  assign out_awready = (aq_count_q != AQ_FULL);
  assign out_wready  = (aq_count_q != '0) && (bq_count_q != BQ_FULL);
  assign out_bvalid  = (bq_count_q != '0);

  assign aw_fire = in_awvalid && out_awready;
  assign w_fire  = in_wvalid && out_wready;
  assign b_fire  = out_bvalid && in_bready;

  // The burst length comes from AWLEN alone; WLAST only feeds the error check.
  assign terminal  = (beat_cnt_q == head_len);
  assign beat_err  = (in_wid != head_id) || (in_wlast != terminal);
  assign burst_err = err_q || beat_err;
  assign aq_pop    = w_fire && terminal;
  assign bq_push   = aq_pop;
  assign push_resp = burst_err ? RESP_SLVERR : RESP_OKAY;

  assign mem_we    = w_fire;
  assign mem_addr  = w_fire ? (head_addr + (AXI_ADDR_W'(beat_cnt_q) << 2)) : '0;
  assign mem_wdata = w_fire ? in_wdata : '0;
  assign mem_wstrb = w_fire ? in_wstrb : 4'h0;

  assign out_bid   = out_bvalid ? bq_id_q[bq_rd_ptr_q]   : '0;
  assign out_bresp = out_bvalid ? bq_resp_q[bq_rd_ptr_q] : RESP_OKAY;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    aq_wr_ptr_d = aq_wr_ptr_q;
    aq_rd_ptr_d = aq_rd_ptr_q;
    aq_count_d  = aq_count_q;
    if (aw_fire) begin
      aq_wr_ptr_d = aq_wr_ptr_q + AQ_PW'(1);
    end
    if (aq_pop) begin
      aq_rd_ptr_d = aq_rd_ptr_q + AQ_PW'(1);
    end
    case ({aw_fire, aq_pop})
      2'b10:   aq_count_d = aq_count_q + AQ_CW'(1);
      2'b01:   aq_count_d = aq_count_q - AQ_CW'(1);
      default: aq_count_d = aq_count_q;
    endcase
  end

  always_comb begin
    bq_wr_ptr_d = bq_wr_ptr_q;
    bq_rd_ptr_d = bq_rd_ptr_q;
    bq_count_d  = bq_count_q;
    if (bq_push) begin
      bq_wr_ptr_d = bq_wr_ptr_q + BQ_PW'(1);
    end
    if (b_fire) begin
      bq_rd_ptr_d = bq_rd_ptr_q + BQ_PW'(1);
    end
    case ({bq_push, b_fire})
      2'b10:   bq_count_d = bq_count_q + BQ_CW'(1);
      2'b01:   bq_count_d = bq_count_q - BQ_CW'(1);
      default: bq_count_d = bq_count_q;
    endcase
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    if (w_fire) begin
      if (terminal) begin
        beat_cnt_d = 4'd0;
        err_d      = 1'b0;
        if (burst_err && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end else begin
        beat_cnt_d = beat_cnt_q + 4'd1;
        err_d      = burst_err;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aq_wr_ptr_q <= '0;
      aq_rd_ptr_q <= '0;
      aq_count_q  <= '0;
      bq_wr_ptr_q <= '0;
      bq_rd_ptr_q <= '0;
      bq_count_q  <= '0;
      beat_cnt_q  <= 4'd0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      aq_wr_ptr_q <= aq_wr_ptr_d;
      aq_rd_ptr_q <= aq_rd_ptr_d;
      aq_count_q  <= aq_count_d;
      bq_wr_ptr_q <= bq_wr_ptr_d;
      bq_rd_ptr_q <= bq_rd_ptr_d;
      bq_count_q  <= bq_count_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Queue payload storage needs no reset: entries are only read while counted.
  always_ff @(posedge aclk) begin
    if (aw_fire) begin
      aq_addr_q[aq_wr_ptr_q] <= in_awaddr;
      aq_len_q[aq_wr_ptr_q]  <= in_awlen;
      aq_id_q[aq_wr_ptr_q]   <= in_awid;
    end
    if (bq_push) begin
      bq_id_q[bq_wr_ptr_q]   <= head_id;
      bq_resp_q[bq_wr_ptr_q] <= push_resp;
    end
  end

endmodule

// File: tb/tb_axi_slv_wr_responder.sv
// Bench for axi_slv_wr_responder: directed corner cases plus randomized bursts
// scored against a burst-level model of expected memory writes and B responses.
module tb_axi_slv_wr_responder;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        in_awvalid = 1'b0;
  logic        out_awready;
  logic [31:0] in_awaddr = '0;
  logic [3:0]  in_awlen = '0;
  logic [3:0]  in_awid = '0;
  logic        in_wvalid = 1'b0;
  logic        out_wready;
  logic        in_wlast = 1'b0;
  logic [3:0]  in_wid = '0;
  logic [31:0] in_wdata = '0;
  logic [3:0]  in_wstrb = '0;
  logic        out_bvalid;
  logic        in_bready = 1'b1;
  logic [3:0]  out_bid;
  logic [1:0]  out_bresp;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [7:0]  err_cnt;

  axi_slv_wr_responder dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_awvalid(in_awvalid), .out_awready(out_awready), .in_awaddr(in_awaddr),
    .in_awlen(in_awlen), .in_awid(in_awid),
    .in_wvalid(in_wvalid), .out_wready(out_wready), .in_wlast(in_wlast),
    .in_wid(in_wid), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
    .out_bvalid(out_bvalid), .in_bready(in_bready), .out_bid(out_bid),
    .out_bresp(out_bresp),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .err_cnt(err_cnt)
  );

  // clock / reset block
  always #5 aclk = ~aclk;

  initial begin
    #900_000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  // kind: 0 clean, 1 WID mismatch on beat eb, 2 WLAST only on beat eb (< len),
  // 3 WLAST never asserted
  typedef struct packed {
    logic [31:0]       addr;
    logic [3:0]        len;
    logic [3:0]        id;
    logic [1:0]        kind;
    logic [3:0]        eb;
    logic [15:0][31:0] data;
    logic [15:0][3:0]  strb;
  } burst_t;

  logic [67:0] exp_mem_q[$];
  logic [5:0]  exp_b_q[$];
  burst_t      bl[$];
  int          errors = 0;
  int          checks = 0;
  int          model_err = 0;
  int          gap_max = 0;
  bit          abort = 0;

  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic burst_t mk(input logic [31:0] addr, input logic [3:0] len,
                                input logic [3:0] id, input logic [1:0] kind,
                                input logic [3:0] eb);
    burst_t b;
    b.addr = addr; b.len = len; b.id = id; b.kind = kind; b.eb = eb;
    for (int i = 0; i < 16; i++) begin
      b.data[i] = $urandom;
      b.strb[i] = 4'($urandom_range(0, 15));
    end
    return b;
  endfunction

  function automatic logic beat_last(input burst_t b, input int i);
    case (b.kind)
      2'd2:    return (i == int'(b.eb));
      2'd3:    return 1'b0;
      default: return (i == int'(b.len));
    endcase
  endfunction

  function automatic logic [3:0] beat_wid(input burst_t b, input int i);
    return (b.kind == 2'd1 && i == int'(b.eb)) ? b.id + 4'd1 : b.id;
  endfunction

  // reference model: each burst writes len+1 consecutive words from its start
  // address and yields one response, SLVERR if any beat was malformed
  task automatic plan(input burst_t b);
    for (int i = 0; i <= int'(b.len); i++)
      exp_mem_q.push_back({b.addr + 32'(4 * i), b.data[i], b.strb[i]});
    exp_b_q.push_back({b.id, (b.kind != 2'd0) ? 2'b10 : 2'b00});
    if (b.kind != 2'd0) model_err++;
  endtask

  task automatic add(input burst_t b);
    plan(b);
    bl.push_back(b);
  endtask

  // driver tasks: called at posedge+1, return at posedge+1 after the handshake
  task automatic idle(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic drive_aw(input burst_t b);
    in_awvalid = 1'b1; in_awaddr = b.addr; in_awlen = b.len; in_awid = b.id;
  endtask

  task automatic send_aw(input burst_t b);
    int n = 0;
    if (abort) return;
    drive_aw(b);
    @(negedge aclk);
    while (!out_awready && n < 2000) begin n++; @(negedge aclk); end
    if (!out_awready) begin chk("aw_wait", out_awready, 1); abort = 1; end
    @(posedge aclk); #1;
    in_awvalid = 1'b0;
  endtask

  task automatic drive_beat(input burst_t b, input int i);
    in_wvalid = 1'b1; in_wid = beat_wid(b, i); in_wdata = b.data[i];
    in_wstrb = b.strb[i]; in_wlast = beat_last(b, i);
  endtask

  task automatic send_beat(input burst_t b, input int i);
    int n = 0;
    if (abort) return;
    drive_beat(b, i);
    @(negedge aclk);
    while (!out_wready && n < 2000) begin n++; @(negedge aclk); end
    if (!out_wready) begin chk("w_wait", out_wready, 1); abort = 1; end
    @(posedge aclk); #1;
    in_wvalid = 1'b0;
  endtask

  task automatic send_w(input burst_t b);
    for (int i = 0; i <= int'(b.len); i++) begin
      idle($urandom_range(0, gap_max));
      send_beat(b, i);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_b_q.size() != 0 || exp_mem_q.size() != 0) && n < 3000 && !abort) begin
      @(posedge aclk); #1; n++;
    end
    chk("drain_b", 68'(exp_b_q.size()), 0);
    chk("drain_mem", 68'(exp_mem_q.size()), 0);
  endtask

  task automatic check_err_cnt();
    chk("err_cnt", err_cnt, (model_err > 255) ? 255 : model_err);
  endtask

  task automatic run_phase(input bit rnd_ready);
    fork
      begin
        foreach (bl[i]) begin
          idle($urandom_range(0, gap_max));
          send_aw(bl[i]);
        end
      end
      begin
        foreach (bl[j]) send_w(bl[j]);
      end
      begin
        int n = 0;
        while (exp_b_q.size() != 0 && n < 30000 && !abort) begin
          @(posedge aclk); #1;
          in_bready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
          n++;
        end
        in_bready = 1'b1;
      end
    join
    bl.delete();
    wait_drain();
    check_err_cnt();
  endtask

  // scoreboard / protocol monitor
  logic       prev_hold = 1'b0;
  logic [5:0] prev_b = '0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("b_hold_valid", out_bvalid, 1);
        chk("b_hold_payload", {out_bid, out_bresp}, prev_b);
      end
      if (mem_we || (in_wvalid && out_wready))
        chk("mem_we", mem_we, in_wvalid && out_wready);
      if (mem_we) begin
        if (exp_mem_q.size() == 0) chk("mem_extra", mem_we, 0);
        else chk("mem_beat", {mem_addr, mem_wdata, mem_wstrb}, exp_mem_q.pop_front());
      end
      if (out_bvalid && in_bready) begin
        if (exp_b_q.size() == 0) chk("b_extra", out_bvalid, 0);
        else chk("b_resp", {out_bid, out_bresp}, exp_b_q.pop_front());
      end
      prev_hold = out_bvalid && !in_bready;
      prev_b    = {out_bid, out_bresp};
    end
  end

  initial begin
    burst_t b;
    burst_t t2[5];
    burst_t t5[5];
    logic [31:0] a;
    logic [3:0]  len;
    logic [1:0]  kind;
    logic [3:0]  eb;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("rst_awready", out_awready, 1);
    chk("rst_wready", out_wready, 0);
    chk("rst_bvalid", out_bvalid, 0);
    chk("rst_bid", out_bid, 0);
    chk("rst_bresp", out_bresp, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(posedge aclk); #1;

    // single burst, B one cycle after the terminal beat
    b = mk(32'h100, 4'd3, 4'd4, 2'd0, 4'd0);
    plan(b);
    send_aw(b);
    send_w(b);
    @(negedge aclk);
    chk("b_latency", out_bvalid, 1);
    @(posedge aclk); #1;
    wait_drain();

    // AW queue fills at four; the fifth waits for the first terminal beat
    for (int i = 0; i < 5; i++) begin
      t2[i] = mk(32'h200 + 32'(i * 64), 4'd0, 4'(i), 2'd0, 4'd0);
      plan(t2[i]);
    end
    for (int i = 0; i < 4; i++) send_aw(t2[i]);
    @(negedge aclk);
    chk("aw_full", out_awready, 0);
    drive_aw(t2[4]);
    repeat (2) begin @(negedge aclk); chk("aw_stall", out_awready, 0); end
    @(posedge aclk); #1;
    drive_beat(t2[0], 0);
    @(negedge aclk);
    chk("w_ready_full", out_wready, 1);
    chk("aw_no_bypass", out_awready, 0);
    @(posedge aclk); #1;
    in_wvalid = 1'b0;
    @(negedge aclk);
    chk("aw_reopen", out_awready, 1);
    @(posedge aclk); #1;
    in_awvalid = 1'b0;
    for (int i = 1; i < 5; i++) send_w(t2[i]);
    wait_drain();

    // WLAST early, WLAST missing, WID mismatch
    add(mk(32'h300, 4'd2, 4'd1, 2'd2, 4'd1));
    add(mk(32'h400, 4'd0, 4'd2, 2'd3, 4'd0));
    add(mk(32'h500, 4'd1, 4'd5, 2'd1, 4'd1));
    run_phase(1'b0);

    // B queue backpressure
    in_bready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      t5[i] = mk(32'h600 + 32'(i * 16), 4'd0, 4'(i + 8), 2'd0, 4'd0);
      plan(t5[i]);
    end
    fork
      begin for (int i = 0; i < 5; i++) send_aw(t5[i]); end
      begin for (int k = 0; k < 4; k++) send_w(t5[k]); end
    join
    drive_beat(t5[4], 0);
    repeat (3) begin @(negedge aclk); chk("bq_full_wready", out_wready, 0); end
    @(posedge aclk); #1;
    in_bready = 1'b1;
    send_beat(t5[4], 0);
    wait_drain();

    // randomized bursts, including address wrap and strobe-free beats
    gap_max = 2;
    for (int n = 0; n < 120; n++) begin
      len = 4'($urandom_range(0, 15));
      a = $urandom;
      a[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF8;
      kind = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if (kind == 2'd2 && len == 4'd0) kind = 2'd3;
      eb = (kind == 2'd2) ? 4'($urandom_range(0, int'(len) - 1))
                          : 4'($urandom_range(0, int'(len)));
      add(mk(a, len, 4'($urandom_range(0, 15)), kind, eb));
    end
    run_phase(1'b1);

    // drive err_cnt into saturation
    gap_max = 0;
    for (int n = 0; n < 260; n++)
      add(mk(32'h1000 + 32'(n * 4), 4'd0, 4'(n), 2'd3, 4'd0));
    run_phase(1'b0);

    // asynchronous reset in the middle of a burst
    b = mk(32'h800, 4'd3, 4'd3, 2'd0, 4'd0);
    send_aw(b);
    for (int i = 0; i < 2; i++) begin
      exp_mem_q.push_back({b.addr + 32'(4 * i), b.data[i], b.strb[i]});
      send_beat(b, i);
    end
    @(negedge aclk);
    aresetn = 1'b0;
    model_err = 0;
    #1;
    chk("mid_rst_bvalid", out_bvalid, 0);
    chk("mid_rst_awready", out_awready, 1);
    chk("mid_rst_wready", out_wready, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    b = mk(32'h900, 4'd0, 4'd7, 2'd0, 4'd0);
    plan(b);
    send_aw(b);
    send_w(b);
    wait_drain();
    check_err_cnt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
